// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux selects and ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields in, control strobes and selects out.
interface mc_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;

  modport master (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, Branch, ALUControl, FlagW
  );

  modport slave (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, Branch, ALUControl, FlagW
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the DP cmd/S fields to an ALU op and flag-write enables when the FSM asks for it.
module mc_aludec
  import mc_pkg::*;
(
  input  logic       alu_op,
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);
  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      // Unsupported commands fall back to ADD and never touch the flags.
      unique case (cmd)
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = {s_bit, s_bit}; end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = {s_bit, s_bit}; end
        CMD_AND: begin alu_control = ALU_AND; flag_w = {s_bit, 1'b0};  end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = {s_bit, 1'b0};  end
        default: begin alu_control = ALU_ADD; flag_w = 2'b00;          end
      endcase
    end
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: Moore FSM over FETCH/DECODE/execute states; outputs decode from state and Funct.
module mc_controller
  import mc_pkg::*;
(
  input logic  clk,
  input logic  reset,
  mc_if.slave  bus
);
  state_t state;
  logic   alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (bus.Op)
            2'b00:   state <= bus.Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= UNKNOWN;
          endcase
        end
        MEMADR:   state <= bus.Funct[0] ? MEMRD : MEMWR;
        MEMRD:    state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // Outputs are combinational on the state so an async reset shows the FETCH decode immediately.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_RD2;
    bus.ResultSrc = RES_ALUOUT;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    alu_op        = 1'b0;
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
      end
      MEMADR: bus.ALUSrcB = SRCB_IMM;
      MEMRD:  bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegW      = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = 1'b1;
      end
      ALUWB: bus.RegW = 1'b1;
      BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        bus.Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .alu_op      (alu_op),
    .funct       (bus.Funct[4:0]),
    .alu_control (bus.ALUControl),
    .flag_w      (bus.FlagW)
  );
endmodule
